fetch_unit: RTL and testbench

- Instruction fetch / PC sequencer. It is the supplier end of the decode interface: it fetches the 32-bit instruction word from instruction memory over a req/ack handshake and presents it to the control decoder.
- It consumes the decoder's 2-bit PC-origin select on retire to compute the next PC.
- It sits between instruction memory and the decode/control stage of the core.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencer.
// Fetches one 32-bit word per instruction over a req/ack handshake, presents it to
// decode, and computes the next PC from the decoder's select when it retires.
// Optional feature: define FETCH_TIMEOUT_EN to enable the ack-wait timeout and fetch_err.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  orig_pc,
    input  logic [31:0] branch_imm,
    input  logic        alu_zero,
    input  logic [31:0] alu_result,
    output logic        misaligned,
    output logic        fetch_err,
    output logic [31:0] retired_count
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    // Reject configurations that can never work.
    if (RESET_PC[1:0] != 2'b00 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("fetch_unit: RESET_PC must be word-aligned and TIMEOUT_CYCLES non-zero");
    end

    typedef enum logic [1:0] {
        StReq,
        StValid,
        StHalt
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WaitW =
        (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

    logic [WaitW-1:0] wait_cnt;
`else
    assign fetch_err = 1'b0;
`endif

    // The address is the architectural PC; it only changes outside REQ, so it is
    // stable for the whole time imem_req is high.
    assign imem_addr = pc;

    // Next-PC selection, always relative to the PC of the instruction being retired.
    always_comb begin
        next_pc = instr_pc + 32'd4;
        case (orig_pc)
            2'd0: next_pc = instr_pc + 32'd4;
            2'd1: next_pc = alu_zero ? (instr_pc + branch_imm) : (instr_pc + 32'd4);
            2'd2: next_pc = instr_pc + branch_imm;
            2'd3: next_pc = {alu_result[31:1], 1'b0};
        endcase
    end

    // Fetch sequencer: all outputs are registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= StReq;
            pc            <= RESET_PC;
            imem_req      <= 1'b0;
            instruction   <= Nop;
            instr_pc      <= RESET_PC;
            instr_valid   <= 1'b0;
            misaligned    <= 1'b0;
            retired_count <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
            fetch_err     <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            unique case (state)
                StReq: begin
                    // The first REQ cycle after reset only raises the request, so a
                    // stale ack left over from before reset is never captured.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instruction <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= StValid;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // Ack on the limit cycle is handled above and wins.
                    else if (wait_cnt == WaitLast) begin
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                        state     <= StHalt;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                StValid: begin
                    if (instr_ready) begin
                        retired_count <= retired_count + 32'd1;
                        instr_valid   <= 1'b0;
                        pc            <= next_pc;
                        if (next_pc[1:0] != 2'b00) begin
                            misaligned <= 1'b1;
                            state      <= StHalt;
                        end else begin
                            // Request immediately so back-to-back fetch takes 2 cycles.
                            imem_req <= 1'b1;
                            state    <= StReq;
`ifdef FETCH_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end
                end
                StHalt: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= StHalt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with programmable wait states,
// scoreboard queues for fetch addresses and retired instructions, directed tests.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam logic [31:0] Nop     = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [1:0]  orig_pc = 2'd0;
    logic [31:0] branch_imm = 32'd0;
    logic        alu_zero = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic        misaligned;
    logic        fetch_err;
    logic [31:0] retired_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] mon_e;

    int waits     = 0;
    int wcnt      = 0;
    bit mem_en    = 1'b0;
    bit stray_ack = 1'b0;

    fetch_unit #(
        .RESET_PC      (ResetPc),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .orig_pc      (orig_pc),
        .branch_imm   (branch_imm),
        .alu_zero     (alu_zero),
        .alu_result   (alu_result),
        .misaligned   (misaligned),
        .fetch_err    (fetch_err),
        .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // Memory model, updated just after each rising edge.
    always begin
        @(posedge clock);
        #1;
        if (stray_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (reset || !imem_req || !mem_en) begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end else if (wcnt >= waits) begin
            imem_ack   = 1'b1;
            imem_rdata = rdata_of(imem_addr);
        end else begin
            imem_ack = 1'b0;
            wcnt++;
        end
    end

    // Scoreboard monitor: accepted fetches and retired instructions.
    always @(negedge clock) begin
        if (!reset && imem_req && imem_ack) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fetch_addr: got fetch of %h, expected none", imem_addr);
            end else begin
                check("fetch_addr", imem_addr, exp_addr_q.pop_front());
            end
        end
        if (!reset && instr_valid && instr_ready) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL retire: got retire of pc %h, expected none", instr_pc);
            end else begin
                mon_e = exp_pc_q.pop_front();
                check("retire_pc", instr_pc, mon_e);
                check("retire_instr", instruction, rdata_of(mon_e));
            end
        end
    end

    task automatic expect_fetch(input logic [31:0] a);
        exp_addr_q.push_back(a);
        exp_pc_q.push_back(a);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        instr_ready = 1'b0;
        repeat (2) @(negedge clock);
        exp_addr_q.delete();
        exp_pc_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!instr_valid && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!instr_valid) fail_now(name);
    endtask

    // Retire the presented instruction with the given next-PC controls.
    task automatic retire(input logic [1:0] sel, input logic [31:0] imm, input logic zero,
                          input logic [31:0] alu, input bit push, input logic [31:0] nxt);
        wait_valid("retire_wait");
        orig_pc    = sel;
        branch_imm = imm;
        alu_zero   = zero;
        alu_result = alu;
        if (push) expect_fetch(nxt);
        instr_ready = 1'b1;
        @(posedge clock);
        #1;
        instr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_instruction", instruction, Nop);
        check("rst_instr_pc", instr_pc, ResetPc);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        check("rst_retired", retired_count, 32'd0);

        // Zero-wait memory, ready held high: one instruction every two cycles
        mem_en = 1'b1;
        waits  = 0;
        for (int i = 0; i < 5; i++) expect_fetch(32'(i * 4));
        reset       = 1'b0;
        instr_ready = 1'b1;
        n = 0;
        while (retired_count != 32'd4 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        instr_ready = 1'b0;
        check("thru_cycles", 32'(n), 32'd9);
        check("thru_retired", retired_count, 32'd4);
        repeat (4) @(posedge clock);
        #1;
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_pc", instr_pc, 32'h10);
        check("hold_instr", instruction, rdata_of(32'h10));
        check("hold_req", {31'd0, imem_req}, 32'd0);
        check("hold_retired", retired_count, 32'd4);
        check("thru_addr_q", 32'(exp_addr_q.size()), 32'd0);

        // Three wait states: address held for four request cycles
        waits = 3;
        do_reset();
        expect_fetch(32'h0);
        n = 0;
        for (int i = 0; i < 30 && !instr_valid; i++) begin
            @(negedge clock);
            if (imem_req && imem_addr == 32'h0) n++;
        end
        check("wait_req_cycles", 32'(n), 32'd4);
        check("wait_pc", instr_pc, 32'h0);
        check("wait_instr", instruction, rdata_of(32'h0));
        @(posedge clock);
        #1;

        // Branch / jump selection, wrap-around and misaligned halt
        waits = 0;
        retire(2'd2, 32'h0000_0100, 1'b0, 32'h0, 1'b1, 32'h0000_0100);
        retire(2'd1, 32'hFFFF_FFF8, 1'b1, 32'h0, 1'b1, 32'h0000_00F8);
        retire(2'd1, 32'h0000_0008, 1'b1, 32'h0, 1'b1, 32'h0000_0100);
        retire(2'd1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b1, 32'h0000_0104);
        retire(2'd3, 32'h0, 1'b0, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFC);
        retire(2'd0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0000);
        retire(2'd3, 32'h0, 1'b0, 32'h0000_0203, 1'b0, 32'h0);
        repeat (5) @(posedge clock);
        #1;
        check("halt_misaligned", {31'd0, misaligned}, 32'd1);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        check("halt_req", {31'd0, imem_req}, 32'd0);
        check("halt_addr", imem_addr, 32'h0000_0202);
        check("halt_retired", retired_count, 32'd7);
        check("halt_fetch_err", {31'd0, fetch_err}, 32'd0);
        check("halt_addr_q", 32'(exp_addr_q.size()), 32'd0);
        check("halt_pc_q", 32'(exp_pc_q.size()), 32'd0);

        // Recovery from halt by reset
        do_reset();
        expect_fetch(ResetPc);
        wait_valid("recover_wait");
        check("recover_misaligned", {31'd0, misaligned}, 32'd0);
        check("recover_pc", instr_pc, ResetPc);
        retire(2'd0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4);

        // Reset in the middle of a request, with an ack pending across reset
        waits = 10;
        do_reset();
        repeat (3) @(posedge clock);
        #3;
        check("midreq_req", {31'd0, imem_req}, 32'd1);
        reset     = 1'b1;
        stray_ack = 1'b1;
        #1;
        check("midreq_async_req", {31'd0, imem_req}, 32'd0);
        repeat (2) @(negedge clock);
        check("midreq_instr", instruction, Nop);
        check("midreq_valid", {31'd0, instr_valid}, 32'd0);
        check("midreq_retired", retired_count, 32'd0);
        exp_addr_q.delete();
        exp_pc_q.delete();
        expect_fetch(ResetPc);
        waits     = 0;
        stray_ack = 1'b0;
        reset     = 1'b0;
        @(posedge clock);
        #1;
        check("stale_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("stale_ack_req", {31'd0, imem_req}, 32'd1);
        check("stale_ack_addr", imem_addr, ResetPc);
        @(posedge clock);
        #1;
        check("postrst_valid", {31'd0, instr_valid}, 32'd1);
        check("postrst_instr", instruction, rdata_of(ResetPc));
        check("postrst_addr_q", 32'(exp_addr_q.size()), 32'd0);

`ifdef FETCH_TIMEOUT_EN
        // No ack: error after four request cycles
        mem_en = 1'b0;
        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (fetch_err) break;
            if (imem_req) n++;
        end
        check("to_req_cycles", 32'(n), 32'd4);
        check("to_fetch_err", {31'd0, fetch_err}, 32'd1);
        check("to_misaligned", {31'd0, misaligned}, 32'd0);
        check("to_req", {31'd0, imem_req}, 32'd0);
`else
        // No ack: request simply keeps waiting
        mem_en = 1'b0;
        do_reset();
        repeat (12) @(negedge clock);
        check("noto_fetch_err", {31'd0, fetch_err}, 32'd0);
        check("noto_req", {31'd0, imem_req}, 32'd1);
        check("noto_valid", {31'd0, instr_valid}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
